// File: rtl/seg7_pkg.sv
// Shared 7-segment constants, BCD digit type and the BCD up/down step helper
// used by the seconds counter display.
package seg7_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   typedef struct packed {
      logic        wrap;
      logic [15:0] value;
   } bcd_step_t;

   function automatic bcd_step_t bcd_step(input logic [15:0] value, input logic up);
      bcd_step_t  result;
      logic       carry;
      bcd_digit_t d;
      result.value = value;
      carry        = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = value[i*4 +: 4];
         if (!carry) begin
            result.value[i*4 +: 4] = d;
         end else if (up) begin
            if (d >= 4'd9) begin
               result.value[i*4 +: 4] = 4'd0;
               carry                  = 1'b1;
            end else begin
               result.value[i*4 +: 4] = d + 4'd1;
               carry                  = 1'b0;
            end
         end else begin
            // An out-of-range digit is forced back to 9 rather than decremented
            if (d == 4'd0) begin
               result.value[i*4 +: 4] = 4'd9;
               carry                  = 1'b1;
            end else if (d > 4'd9) begin
               result.value[i*4 +: 4] = 4'd9;
               carry                  = 1'b0;
            end else begin
               result.value[i*4 +: 4] = d - 4'd1;
               carry                  = 1'b0;
            end
         end
      end
      result.wrap = carry;
      return result;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment decoder; codes 10-15 show blank.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  bcd_digit_t  digit,
   output logic [6:0]  segments
);

   // Digit decode
   always_comb begin
      segments = SEG_BLANK;
      case (digit)
         4'd0:    segments = SEG_DIGIT[0];
         4'd1:    segments = SEG_DIGIT[1];
         4'd2:    segments = SEG_DIGIT[2];
         4'd3:    segments = SEG_DIGIT[3];
         4'd4:    segments = SEG_DIGIT[4];
         4'd5:    segments = SEG_DIGIT[5];
         4'd6:    segments = SEG_DIGIT[6];
         4'd7:    segments = SEG_DIGIT[7];
         4'd8:    segments = SEG_DIGIT[8];
         4'd9:    segments = SEG_DIGIT[9];
         default: segments = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_counter_display.sv
// 4-digit BCD up/down seconds counter fed by the 1 Hz divider output, driving a
// time-multiplexed common-anode 7-segment display.
module bcd_counter_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_BITS  = 17,
   parameter int SYNC_STAGES   = 2,
   parameter int BLANK_LEADING = 1
) (
   input  logic                    clk_100MHz,
   input  logic                    reset,
   input  logic                    clk_1Hz,
   input  logic                    enable,
   input  logic                    up_down,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    rollover,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [6:0]              segments,
   output logic                    dp
);

   localparam logic BLANK_EN = (BLANK_LEADING != 0);

   logic [SYNC_STAGES-1:0]  sync_r;
   logic                    edge_r;
   logic                    tick_s;
   logic [15:0]             count_r;
   logic                    rollover_r;
   bcd_step_t               step_s;
   logic [REFRESH_BITS-1:0] refresh_r;
   logic [1:0]              sel_s;
   logic [3:1]              lead_zero_s;
   bcd_digit_t              digit_s;
   logic                    blank_s;
   logic [3:0]              anode_s;
   logic                    dp_s;
   logic [6:0]              digit_seg_s;
   logic [3:0]              anodes_r;
   logic [6:0]              segments_r;
   logic                    dp_r;

   // Synchroniser and edge detector; reset high so a level already high is not a tick
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{1'b1}};
         edge_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], clk_1Hz};
         edge_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign tick_s = sync_r[SYNC_STAGES-1] & ~edge_r;
   assign step_s = bcd_step(count_r, up_down);

   // BCD counter: clear beats tick, ticks while paused are discarded
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         count_r    <= 16'h0000;
         rollover_r <= 1'b0;
      end else if (clear) begin
         count_r    <= 16'h0000;
         rollover_r <= 1'b0;
      end else if (tick_s && enable) begin
         count_r    <= step_s.value;
         rollover_r <= step_s.wrap;
      end else begin
         rollover_r <= 1'b0;
      end
   end

   // Free-running display refresh counter
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         refresh_r <= '0;
      end else begin
         refresh_r <= refresh_r + REFRESH_BITS'(1);
      end
   end

   assign sel_s = refresh_r[REFRESH_BITS-1 -: 2];

   // Digit select, leading-zero blanking and pause indicator
   always_comb begin
      lead_zero_s[3] = (count_r[15:12] == 4'd0);
      lead_zero_s[2] = lead_zero_s[3] & (count_r[11:8] == 4'd0);
      lead_zero_s[1] = lead_zero_s[2] & (count_r[7:4] == 4'd0);
      digit_s = 4'd0;
      blank_s = 1'b1;
      anode_s = ANODE_OFF;
      case (sel_s)
         2'd0: begin
            digit_s = count_r[3:0];
            blank_s = 1'b0;
            anode_s = 4'b1110;
         end
         2'd1: begin
            digit_s = count_r[7:4];
            blank_s = BLANK_EN & lead_zero_s[1];
            anode_s = 4'b1101;
         end
         2'd2: begin
            digit_s = count_r[11:8];
            blank_s = BLANK_EN & lead_zero_s[2];
            anode_s = 4'b1011;
         end
         2'd3: begin
            digit_s = count_r[15:12];
            blank_s = BLANK_EN & lead_zero_s[3];
            anode_s = 4'b0111;
         end
         default: begin
            digit_s = 4'd0;
            blank_s = 1'b1;
            anode_s = ANODE_OFF;
         end
      endcase
      if ((sel_s == 2'd0) && !enable) begin
         dp_s = 1'b0;
      end else begin
         dp_s = 1'b1;
      end
   end

   bcd_to_seg7 u_decode (
      .digit    (digit_s),
      .segments (digit_seg_s)
   );

   // Registered display drive
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         anodes_r   <= ANODE_OFF;
         segments_r <= SEG_BLANK;
         dp_r       <= 1'b1;
      end else begin
         anodes_r   <= anode_s;
         segments_r <= blank_s ? SEG_BLANK : digit_seg_s;
         dp_r       <= dp_s;
      end
   end

   assign count_bcd = count_r;
   assign rollover  = rollover_r;
   assign anodes    = anodes_r;
   assign segments  = segments_r;
   assign dp        = dp_r;

endmodule
